// File: rtl/wb_stage_if.sv
// Handshake and register-file bus of the rv32i write-back stage.
// Signal names keep the stage's point of view: i_* flow into wb_stage,
// o_* flow out of it.
interface wb_stage_if;
    logic        i_valid;
    logic        o_ready;
    logic        i_flush;
    logic [4:0]  i_rd;
    logic        i_reg_write;
    logic [1:0]  i_wb_sel;
    logic [2:0]  i_funct3;
    logic [31:0] i_alu_result;
    logic [31:0] i_pc_plus4;
    logic [31:0] i_imm;
    logic        i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic [4:0]  o_WA;
    logic [31:0] o_WD;
    logic        o_WE;
    logic [31:0] o_instret;
    logic        o_load_fault;

    // MEM stage / data memory side
    modport master (
        output i_valid, i_flush, i_rd, i_reg_write, i_wb_sel, i_funct3,
               i_alu_result, i_pc_plus4, i_imm, i_dmem_rvalid, i_dmem_rdata,
        input  o_ready, o_WA, o_WD, o_WE, o_instret, o_load_fault
    );

    // Write-back stage side
    modport slave (
        input  i_valid, i_flush, i_rd, i_reg_write, i_wb_sel, i_funct3,
               i_alu_result, i_pc_plus4, i_imm, i_dmem_rvalid, i_dmem_rdata,
        output o_ready, o_WA, o_WD, o_WE, o_instret, o_load_fault
    );
endinterface

// File: rtl/wb_stage.sv
// rv32i write-back stage: accepts one retiring instruction, waits for load
// data when needed, formats it and drives the register-file write port.
// Also counts retired instructions and flags loads that never get data.
module wb_stage #(
    parameter int XLEN     = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    wb_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOAD = 2'd1,
        COMMIT    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic [1:0]        wb_sel_q, wb_sel_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic [XLEN-1:0]   imm_q, imm_d;
    logic [4:0]        wa_q, wa_d;
    logic [XLEN-1:0]   wd_q, wd_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   instret_q, instret_d;
    logic              fault_q, fault_d;
    logic              ready_s;
    logic              accept_s;

    // Extract, align and extend the addressed part of a memory word.
    function automatic logic [31:0] load_format(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res;
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            2'd3:    byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{24{byte_v[7]}}, byte_v};
            3'b001:  res = {{16{half_v[15]}}, half_v};
            3'b010:  res = word;
            3'b100:  res = {24'd0, byte_v};
            3'b101:  res = {16'd0, half_v};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Write-back source multiplexer.
    function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                              input logic [31:0] alu,
                                              input logic [31:0] load,
                                              input logic [31:0] pc4,
                                              input logic [31:0] imm);
        logic [31:0] res;
        case (sel)
            2'b00:   res = alu;
            2'b01:   res = load;
            2'b10:   res = pc4;
            2'b11:   res = imm;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    assign ready_s  = (state_q != WAIT_LOAD);
    assign accept_s = bus.i_valid && ready_s && !bus.i_flush;

    assign bus.o_ready      = ready_s;
    assign bus.o_WA         = wa_q;
    assign bus.o_WD         = wd_q;
    assign bus.o_WE         = we_q;
    assign bus.o_instret    = instret_q;
    assign bus.o_load_fault = fault_q;

    // Next-state, capture and register-file write computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        wb_sel_d    = wb_sel_q;
        funct3_d    = funct3_q;
        alu_d       = alu_q;
        pc4_d       = pc4_q;
        imm_d       = imm_q;
        wa_d        = wa_q;
        wd_d        = wd_q;
        we_d        = 1'b0;
        instret_d   = instret_q;
        fault_d     = 1'b0;

        case (state_q)
            IDLE, COMMIT: begin
                if (accept_s) begin
                    rd_d        = bus.i_rd;
                    reg_write_d = bus.i_reg_write;
                    wb_sel_d    = bus.i_wb_sel;
                    funct3_d    = bus.i_funct3;
                    alu_d       = bus.i_alu_result;
                    pc4_d       = bus.i_pc_plus4;
                    imm_d       = bus.i_imm;
                    if (bus.i_wb_sel != 2'b01) begin
                        // Non-loads write straight from the inputs so the
                        // pulse lands one cycle after acceptance.
                        state_d   = COMMIT;
                        we_d      = bus.i_reg_write && (bus.i_rd != 5'd0);
                        wa_d      = bus.i_rd;
                        wd_d      = wb_select(bus.i_wb_sel, bus.i_alu_result,
                                              32'd0, bus.i_pc_plus4, bus.i_imm);
                        instret_d = instret_q + 32'd1;
                    end else begin
                        state_d = WAIT_LOAD;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_LOAD: begin
                if (bus.i_flush) begin
                    // Flush beats a simultaneous response.
                    state_d = IDLE;
                end else if (bus.i_dmem_rvalid) begin
                    state_d   = COMMIT;
                    we_d      = reg_write_q && (rd_q != 5'd0);
                    wa_d      = rd_q;
                    wd_d      = wb_select(wb_sel_q, alu_q,
                                          load_format(funct3_q, alu_q[1:0], bus.i_dmem_rdata),
                                          pc4_q, imm_q);
                    instret_d = instret_q + 32'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == WAIT_MAX[7:0]) begin
                        state_d = IDLE;
                        fault_d = 1'b1;
                    end else begin
                        state_d = WAIT_LOAD;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, captured fields and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            rd_q        <= 5'd0;
            reg_write_q <= 1'b0;
            wb_sel_q    <= 2'b00;
            funct3_q    <= 3'b000;
            alu_q       <= 32'd0;
            pc4_q       <= 32'd0;
            imm_q       <= 32'd0;
            wa_q        <= 5'd0;
            wd_q        <= 32'd0;
            we_q        <= 1'b0;
            instret_q   <= 32'd0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            wb_sel_q    <= wb_sel_d;
            funct3_q    <= funct3_d;
            alu_q       <= alu_d;
            pc4_q       <= pc4_d;
            imm_q       <= imm_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            we_q        <= we_d;
            instret_q   <= instret_d;
            fault_q     <= fault_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the stimulus process pushes expected
// register-file events, the monitor pops and compares them at negedges.
module tb_wb_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    wb_stage_if bus ();

    wb_stage #(.XLEN(32), .WAIT_MAX(15)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic        we;
        logic        fault;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] instret;
    } ev_t;

    ev_t         exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_instret = 32'd0;
    logic [31:0] mon_last    = 32'd0;

    // Reference load formatting, by arithmetic on the word.
    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] addr,
                                             input logic [31:0] w);
        longint v;
        int     off;
        off = int'(addr & 32'd3);
        case (f3)
            3'd0: begin
                v = longint'((w >> (8 * off)) & 32'hFF);
                if (v >= 128) v = v - 256;
            end
            3'd1: begin
                v = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
                if (v >= 32768) v = v - 65536;
            end
            3'd2:    v = longint'(w);
            3'd4:    v = longint'((w >> (8 * off)) & 32'hFF);
            3'd5:    v = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic push_ev(input logic we, input logic fault, input logic [4:0] wa,
                           input logic [31:0] wd, input logic [31:0] ins);
        ev_t e;
        e.we = we; e.fault = fault; e.wa = wa; e.wd = wd; e.instret = ins;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: any write, fault or instret change is an event to score.
    always @(negedge clk) begin
        ev_t e;
        logic ok;
        if (!rst_n) begin
            mon_last = bus.o_instret;
        end else if (bus.o_WE || bus.o_load_fault || bus.o_instret != mon_last) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got we=%b fault=%b wa=%0d wd=%h instret=%h, want none",
                         bus.o_WE, bus.o_load_fault, bus.o_WA, bus.o_WD, bus.o_instret);
            end else begin
                e  = exp_q.pop_front();
                ok = (bus.o_WE === e.we) && (bus.o_load_fault === e.fault) &&
                     (bus.o_instret === e.instret) &&
                     (!e.we || (bus.o_WA === e.wa && bus.o_WD === e.wd));
                if (!ok) begin
                    bad++;
                    $display("FAIL event: got we=%b fault=%b wa=%0d wd=%h instret=%h, want we=%b fault=%b wa=%0d wd=%h instret=%h",
                             bus.o_WE, bus.o_load_fault, bus.o_WA, bus.o_WD, bus.o_instret,
                             e.we, e.fault, e.wa, e.wd, e.instret);
                end
            end
            mon_last = bus.o_instret;
        end
    end

    task automatic nonload(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] pc4, input logic [31:0] imm);
        logic [31:0] wd;
        bus.i_valid      = 1'b1;
        bus.i_rd         = rd;
        bus.i_reg_write  = rw;
        bus.i_wb_sel     = sel;
        bus.i_funct3     = 3'($urandom);
        bus.i_alu_result = alu;
        bus.i_pc_plus4   = pc4;
        bus.i_imm        = imm;
        wd = (sel == 2'b10) ? pc4 : ((sel == 2'b11) ? imm : alu);
        exp_instret = exp_instret + 32'd1;
        push_ev(rw && (rd != 5'd0), 1'b0, rd, wd, exp_instret);
        tick();
        bus.i_valid = 1'b0;
    endtask

    // mode: 0 data returns, 1 timeout, 2 flush with data, 3 reset mid-wait
    task automatic load(input logic [4:0] rd, input logic rw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rdata,
                        input int delay, input int mode);
        bus.i_valid       = 1'b1;
        bus.i_rd          = rd;
        bus.i_reg_write   = rw;
        bus.i_wb_sel      = 2'b01;
        bus.i_funct3      = f3;
        bus.i_alu_result  = addr;
        bus.i_pc_plus4    = $urandom;
        bus.i_imm         = $urandom;
        bus.i_dmem_rvalid = 1'($urandom);
        bus.i_dmem_rdata  = $urandom;
        tick();
        bus.i_valid       = 1'b0;
        bus.i_dmem_rvalid = 1'b0;
        check("ready_low_in_wait", 32'(bus.o_ready), 32'd0);
        if (mode == 1) begin
            repeat (14) tick();
            check("ready_low_before_timeout", 32'(bus.o_ready), 32'd0);
            push_ev(1'b0, 1'b1, 5'd0, 32'd0, exp_instret);
            tick();
            check("fault_pulse", 32'(bus.o_load_fault), 32'd1);
            check("ready_after_timeout", 32'(bus.o_ready), 32'd1);
            bus.i_dmem_rvalid = 1'b1;
            bus.i_dmem_rdata  = 32'h1234_5678;
            repeat (2) tick();
            bus.i_dmem_rvalid = 1'b0;
            check("stray_rvalid_no_we", 32'(bus.o_WE), 32'd0);
        end else if (mode == 3) begin
            repeat (2) tick();
            #2;
            rst_n = 1'b0;
            #1;
            check("rst_mid_we",      32'(bus.o_WE), 32'd0);
            check("rst_mid_wa",      32'(bus.o_WA), 32'd0);
            check("rst_mid_wd",      bus.o_WD, 32'd0);
            check("rst_mid_instret", bus.o_instret, 32'd0);
            check("rst_mid_ready",   32'(bus.o_ready), 32'd1);
            exp_instret = 32'd0;
            tick();
            rst_n = 1'b1;
            tick();
        end else begin
            repeat (delay - 1) tick();
            bus.i_dmem_rvalid = 1'b1;
            bus.i_dmem_rdata  = rdata;
            bus.i_flush       = (mode == 2);
            if (mode == 0) begin
                exp_instret = exp_instret + 32'd1;
                push_ev(rw && (rd != 5'd0), 1'b0, rd, ref_load(f3, addr, rdata), exp_instret);
            end
            tick();
            bus.i_dmem_rvalid = 1'b0;
            bus.i_flush       = 1'b0;
            check("ready_after_load", 32'(bus.o_ready), 32'd1);
            if (mode == 2) check("flush_no_we", 32'(bus.o_WE), 32'd0);
        end
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_rd = 5'd0; bus.i_reg_write = 1'b0;
        bus.i_wb_sel = 2'b00; bus.i_funct3 = 3'b000; bus.i_alu_result = 32'd0;
        bus.i_pc_plus4 = 32'd0; bus.i_imm = 32'd0; bus.i_dmem_rvalid = 1'b0;
        bus.i_dmem_rdata = 32'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_we",      32'(bus.o_WE), 32'd0);
        check("reset_wa",      32'(bus.o_WA), 32'd0);
        check("reset_wd",      bus.o_WD, 32'd0);
        check("reset_instret", bus.o_instret, 32'd0);
        check("reset_fault",   32'(bus.o_load_fault), 32'd0);
        rst_n = 1'b1;
        tick();
        check("reset_ready", 32'(bus.o_ready), 32'd1);

        // ADD rd=5
        nonload(5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 32'h0);
        check("add_we",      32'(bus.o_WE), 32'd1);
        check("add_wa",      32'(bus.o_WA), 32'd5);
        check("add_wd",      bus.o_WD, 32'h1234);
        check("add_instret", bus.o_instret, 32'd1);
        tick();
        check("add_we_drop", 32'(bus.o_WE), 32'd0);

        // Load formatting cases
        load(5'd7, 1'b1, 3'b000, 32'h0000_1003, 32'h80FF_00AA, 3, 0);
        load(5'd7, 1'b1, 3'b100, 32'h0000_1003, 32'h80FF_00AA, 3, 0);
        load(5'd8, 1'b1, 3'b001, 32'h0000_1002, 32'h80FF_00AA, 2, 0);
        load(5'd8, 1'b1, 3'b101, 32'h0000_1003, 32'h80FF_00AA, 1, 0);
        load(5'd9, 1'b1, 3'b010, 32'h0000_1001, 32'hDEAD_BEEF, 1, 0);
        load(5'd9, 1'b1, 3'b111, 32'h0000_1000, 32'hDEAD_BEEF, 2, 0);

        // Timeout, flush-with-data
        load(5'd3, 1'b1, 3'b010, 32'h0000_2000, 32'h0, 1, 1);
        load(5'd3, 1'b1, 3'b010, 32'h0000_2000, 32'h5555_AAAA, 3, 2);

        // JAL to x0 then LUI to x1, back to back
        nonload(5'd0, 1'b1, 2'b10, 32'h0, 32'h104, 32'h0);
        nonload(5'd1, 1'b1, 2'b11, 32'h0, 32'h0, 32'hABCD_E000);
        check("lui_we", 32'(bus.o_WE), 32'd1);
        check("lui_wd", bus.o_WD, 32'hABCD_E000);

        // Flush in COMMIT only blocks acceptance
        nonload(5'd4, 1'b1, 2'b00, 32'hCAFE_0000, 32'h0, 32'h0);
        bus.i_valid = 1'b1; bus.i_flush = 1'b1;
        tick();
        bus.i_valid = 1'b0; bus.i_flush = 1'b0;

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            int r;
            r = int'($urandom % 10);
            if (r < 5) begin
                int s;
                s = int'($urandom % 3);
                nonload(5'($urandom), 1'($urandom), (s == 0) ? 2'b00 : ((s == 1) ? 2'b10 : 2'b11),
                        $urandom, $urandom, $urandom);
            end else if (r < 8) begin
                load(5'($urandom), 1'($urandom), 3'($urandom), $urandom, $urandom,
                     int'($urandom_range(5, 1)), 0);
            end else if (r == 8) begin
                load(5'($urandom), 1'b1, 3'b010, $urandom, $urandom,
                     int'($urandom_range(4, 1)), 2);
            end else begin
                bus.i_valid = 1'b1; bus.i_flush = 1'b1; bus.i_rd = 5'd2;
                bus.i_reg_write = 1'b1; bus.i_wb_sel = 2'b00;
                tick();
                bus.i_valid = 1'b0; bus.i_flush = 1'b0;
            end
            if ($urandom % 4 == 0) tick();
        end

        // Instret wrap
        force dut.instret_q = 32'hFFFF_FFFE;
        exp_instret = 32'hFFFF_FFFE;
        push_ev(1'b0, 1'b0, 5'd0, 32'd0, exp_instret);
        tick();
        release dut.instret_q;
        nonload(5'd6, 1'b1, 2'b00, 32'h11, 32'h0, 32'h0);
        nonload(5'd6, 1'b1, 2'b00, 32'h22, 32'h0, 32'h0);
        check("instret_wrap", bus.o_instret, 32'd0);
        tick();

        // Reset during a pending load
        load(5'd10, 1'b1, 3'b010, 32'h0, 32'h0, 1, 3);
        nonload(5'd11, 1'b1, 2'b00, 32'h77, 32'h0, 32'h0);
        check("post_reset_instret", bus.o_instret, 32'd1);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the rv32i core; sits directly upstream of the register file.
- Accepts one retiring instruction at a time from the MEM stage and waits for data-memory read data on loads.
- Sign- or zero-extends and aligns load data, then selects the write-back source.
- Drives the register file's write address, write data and write enable. Also keeps a retired-instruction counter and flags load timeouts.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- WAIT_MAX, 15, maximum number of cycles spent in WAIT_LOAD before a load fault is raised (range 1..255).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  MEM stage presents an instruction.
- o_ready  out  1  stage can accept; transfer happens when i_valid && o_ready.
- i_flush  in  1  kill the pending load and block acceptance this cycle.
- i_rd  in  5  destination register.
- i_reg_write  in  1  instruction writes rd.
- i_wb_sel  in  2  write-back source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- i_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_alu_result  in  32  ALU result; for loads, the byte address.
- i_pc_plus4  in  32  link value.
- i_imm  in  32  U-immediate.
- i_dmem_rvalid  in  1  data-memory read data valid.
- i_dmem_rdata  in  32  aligned memory word.
- o_WA  out  5  register file write address.
- o_WD  out  32  register file write data.
- o_WE  out  1  register file write enable (single-cycle pulse).
- o_instret  out  32  retired-instruction count.
- o_load_fault  out  1  one-cycle pulse on load timeout.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE.
  - o_WA=0, o_WD=0, o_WE=0, o_instret=0, o_load_fault=0, captured fields cleared.
  - o_ready=1 once reset releases.
- Outputs: o_WA, o_WD, o_WE, o_load_fault and o_instret are all registered.
- o_ready is combinational: 1 when state is IDLE or COMMIT, 0 in WAIT_LOAD.
- Acceptance: occurs when i_valid && o_ready && !i_flush. On acceptance, capture rd, reg_write, wb_sel, funct3, addr[1:0], alu_result, pc_plus4 and imm.
- State IDLE/COMMIT, on acceptance:
  - Non-load (wb_sel != 01): next state COMMIT. The next edge sets o_WE = reg_write && (rd != 0), o_WA=rd and o_WD = the selected source.
  - Load: next state WAIT_LOAD, wait counter = 0, o_WE=0.
- State IDLE/COMMIT, no acceptance: next state IDLE, o_WE=0.
- COMMIT is a single-cycle state; back-to-back non-loads give a 1-cycle-latency o_WE pulse every cycle.
- State WAIT_LOAD, i_dmem_rvalid=1: format the data and go to COMMIT, with o_WE = reg_write && (rd != 0).
- Load formatting, with byte offset b=addr[1:0]:
  - LB/LBU select byte b; LH/LHU select halfword addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - LH/LW with a misaligned offset use addr[1] (and ignore addr[0]) and addr[1:0]=0 respectively; no trap.
  - Unsupported funct3 writes 0.
- State WAIT_LOAD, no rvalid: increment the wait counter. When the counter reaches WAIT_MAX, pulse o_load_fault for one cycle, return to IDLE, no write, no instret increment.
- i_flush in WAIT_LOAD: return to IDLE, no write, no fault, no count.
- i_flush in IDLE/COMMIT: blocks acceptance only. A COMMIT already registered still completes.
- i_flush and i_dmem_rvalid in the same WAIT_LOAD cycle: flush wins, no write.
- i_dmem_rvalid outside WAIT_LOAD is ignored, including a stale response after a flush or fault. rvalid is not sampled in the acceptance cycle.
- o_instret increments by 1 on every COMMIT entry, including rd=0 and reg_write=0 instructions. It wraps from 0xFFFFFFFF to 0.
- x0 protection: o_WE is never 1 with o_WA=0.
- Reset mid-load: the stage returns immediately to IDLE and the pending load is lost.

Test Plan:
- Reset, then an ADD-type instruction with rd=5, wb_sel=00, alu_result=0x1234 -> next cycle o_WE=1, o_WA=5, o_WD=0x1234, o_instret=1; the following cycle o_WE=0.
- LB with addr=0x...3, rdata=0x80FF00AA, rvalid 3 cycles after acceptance -> o_ready=0 while waiting; then o_WD=0xFFFFFF80 for rd. Repeating with LBU gives 0x00000080. LH with addr[1]=1 gives 0xFFFF80FF; LHU gives 0x000080FF.
- Load with no rvalid and WAIT_MAX=15 -> o_load_fault pulses once 15 cycles after acceptance, no o_WE, o_instret unchanged. A later stray rvalid is ignored.
- Pending load, then i_flush asserted in the same cycle as rvalid -> no write, state IDLE, o_ready=1 the next cycle.
- Back-to-back JAL (wb_sel=10, pc_plus4=0x104) and LUI (wb_sel=11, imm=0xABCDE000) with rd=0 and then rd=1 -> first: o_WE=0 but instret increments; second: o_WE=1, o_WD=0xABCDE000, on consecutive cycles.
- Preload o_instret near wrap by committing past 0xFFFFFFFF (force via bench) -> count wraps to 0. Asserting i_rst_n=0 mid-WAIT_LOAD clears all outputs asynchronously.
